// File: rtl/fp_operand_align.sv
// Single-precision operand aligner: unpacks and classifies A/B, orders them by magnitude,
// and right-shifts the smaller significand one bit per cycle with a sticky LSB.
//  state | meaning
//  IDLE  | waiting for an operand pair (in_ready=1)
//  SHIFT | shifting mantSmall right one bit per cycle until count expires
//  DONE  | result held on the outputs until out_ready
module fp_operand_align #(
    parameter int MAX_SHIFT = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] opA,
    output logic [31:0] opB,
    output logic        ANaN,
    output logic        BNaN,
    output logic        Ainf,
    output logic        Binf,
    output logic        Azero,
    output logic        Bzero,
    output logic        signA,
    output logic        signB,
    output logic        swapped,
    output logic [7:0]  exponentOut,
    output logic [31:0] mantLarge,
    output logic [31:0] mantSmall
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [7:0] MAX_SHIFT_W = 8'(MAX_SHIFT);

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] mant_small_q, mant_small_d;
    logic [31:0] op_a_q, op_b_q, mant_large_q;
    logic [5:0]  flags_q;
    logic [1:0]  signs_q;
    logic        swapped_q;
    logic [7:0]  exp_out_q;

    logic [7:0]  exp_a, exp_b, eff_a, eff_b, e_large, e_small, diff;
    logic [22:0] frac_a, frac_b;
    logic [31:0] sig_a, sig_b, sig_large, sig_small;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        b_larger, special, accept;

    assign exp_a  = A[30:23];
    assign exp_b  = B[30:23];
    assign frac_a = A[22:0];
    assign frac_b = B[22:0];
    assign eff_a  = (exp_a == 8'h00) ? 8'h01 : exp_a;
    assign eff_b  = (exp_b == 8'h00) ? 8'h01 : exp_b;
    assign sig_a  = {exp_a != 8'h00, frac_a, 8'h00};
    assign sig_b  = {exp_b != 8'h00, frac_b, 8'h00};

    assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign a_zero = (exp_a == 8'h00) && (frac_a == 23'd0);
    assign b_zero = (exp_b == 8'h00) && (frac_b == 23'd0);

    // A wins ties so equal magnitudes never report swapped
    assign b_larger  = {eff_b, frac_b} > {eff_a, frac_a};
    assign e_large   = b_larger ? eff_b : eff_a;
    assign e_small   = b_larger ? eff_a : eff_b;
    assign sig_large = b_larger ? sig_b : sig_a;
    assign sig_small = b_larger ? sig_a : sig_b;
    assign diff      = e_large - e_small;
    assign special   = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        mant_small_d = mant_small_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    count_d      = diff;
                    mant_small_d = sig_small;
                    if (special || diff == 8'd0) begin
                        state_d = DONE;
                    end else if (diff > MAX_SHIFT_W) begin
                        mant_small_d = (sig_small != 32'd0) ? 32'h1 : 32'h0;
                        state_d      = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_small_d = {1'b0, mant_small_q[31:2], mant_small_q[1] | mant_small_q[0]};
                count_d      = count_q - 8'd1;
                if (count_q == 8'd1) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 8'd0;
            mant_small_q <= 32'd0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            mant_large_q <= 32'd0;
            flags_q      <= 6'd0;
            signs_q      <= 2'd0;
            swapped_q    <= 1'b0;
            exp_out_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mant_small_q <= mant_small_d;
            if (accept) begin
                op_a_q       <= A;
                op_b_q       <= B;
                mant_large_q <= sig_large;
                flags_q      <= {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero};
                signs_q      <= {A[31], B[31]};
                swapped_q    <= b_larger;
                exp_out_q    <= e_large;
            end
        end
    end

    assign out_valid   = (state_q == DONE);
    assign opA         = op_a_q;
    assign opB         = op_b_q;
    assign {ANaN, BNaN, Ainf, Binf, Azero, Bzero} = flags_q;
    assign {signA, signB} = signs_q;
    assign swapped     = swapped_q;
    assign exponentOut = exp_out_q;
    assign mantLarge   = mant_large_q;
    assign mantSmall   = mant_small_q;
endmodule

// File: tb/tb_fp_operand_align.sv
// Directed bench for fp_operand_align: table of operand pairs with hand-computed alignment
// results and latencies, plus hold-in-DONE and reset-mid-shift sequences.
module tb_fp_operand_align;
    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, opA, opB, mantLarge, mantSmall;
    logic        ANaN, BNaN, Ainf, Binf, Azero, Bzero, signA, signB, swapped;
    logic [7:0]  exponentOut;

    int total = 0;
    int bad   = 0;

    fp_operand_align #(.MAX_SHIFT(26)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .opA(opA), .opB(opB), .ANaN(ANaN), .BNaN(BNaN), .Ainf(Ainf), .Binf(Binf),
        .Azero(Azero), .Bzero(Bzero), .signA(signA), .signB(signB), .swapped(swapped),
        .exponentOut(exponentOut), .mantLarge(mantLarge), .mantSmall(mantSmall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        swp;
        logic [7:0]  ex;
        logic [31:0] ml;
        logic [31:0] ms;
        int          lat;
        logic [5:0]  fl;   // {ANaN,BNaN,Ainf,Binf,Azero,Bzero}
        logic [1:0]  sg;   // {signA,signB}
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Offers the pair right after a rising edge; returns rising edges until out_valid is seen.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            in_valid = 1'b0;
        end while (!out_valid && lat < 200);
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, " swapped"}, {31'd0, swapped}, {31'd0, v.swp});
        chk({tag, " exponentOut"}, {24'd0, exponentOut}, {24'd0, v.ex});
        chk({tag, " mantLarge"}, mantLarge, v.ml);
        chk({tag, " mantSmall"}, mantSmall, v.ms);
        chk({tag, " flags"}, {26'd0, ANaN, BNaN, Ainf, Binf, Azero, Bzero}, {26'd0, v.fl});
        chk({tag, " signs"}, {30'd0, signA, signB}, {30'd0, v.sg});
        chk({tag, " opA"}, opA, v.a);
        chk({tag, " opB"}, opB, v.b);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, " idle out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " idle in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        vec_t v;
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b1, 8'h80, 32'h80000000, 32'h40000000, 2,  6'b000000, 2'b00};
        vecs[1]  = '{32'h4B800000, 32'h3F800001, 1'b0, 8'h97, 32'h80000000, 32'h00000081, 25, 6'b000000, 2'b00};
        vecs[2]  = '{32'h7F000000, 32'h3F800000, 1'b0, 8'hFE, 32'h80000000, 32'h00000001, 1,  6'b000000, 2'b00};
        vecs[3]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 8'hFF, 32'hC0000000, 32'h80000000, 1,  6'b100000, 2'b00};
        vecs[4]  = '{32'h00000000, 32'h3F800000, 1'b1, 8'h7F, 32'h80000000, 32'h00000000, 1,  6'b000010, 2'b00};
        vecs[5]  = '{32'h3F800000, 32'hBF800000, 1'b0, 8'h7F, 32'h80000000, 32'h80000000, 1,  6'b000000, 2'b01};
        vecs[6]  = '{32'h3F800000, 32'h3FC00000, 1'b1, 8'h7F, 32'hC0000000, 32'h80000000, 1,  6'b000000, 2'b00};
        vecs[7]  = '{32'h4C800000, 32'h3F800000, 1'b0, 8'h99, 32'h80000000, 32'h00000020, 27, 6'b000000, 2'b00};
        vecs[8]  = '{32'h4D000000, 32'h3F800000, 1'b0, 8'h9A, 32'h80000000, 32'h00000001, 1,  6'b000000, 2'b00};
        vecs[9]  = '{32'h7F800000, 32'h40000000, 1'b0, 8'hFF, 32'h80000000, 32'h80000000, 1,  6'b001000, 2'b00};
        vecs[10] = '{32'h3F800000, 32'hFFC00001, 1'b1, 8'hFF, 32'hC0000100, 32'h80000000, 1,  6'b010000, 2'b01};
        vecs[11] = '{32'h00000001, 32'h00800000, 1'b0, 8'h01, 32'h00000100, 32'h80000000, 1,  6'b000000, 2'b00};
        vecs[12] = '{32'h41000000, 32'hBF800003, 1'b0, 8'h82, 32'h80000000, 32'h10000060, 4,  6'b000000, 2'b01};
        vecs[13] = '{32'h40400000, 32'h80000000, 1'b0, 8'h80, 32'hC0000000, 32'h00000000, 1,  6'b000001, 2'b01};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = 32'h0; B = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-reset mantSmall", mantSmall, 32'd0);

        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            run_txn(v.a, v.b, lat);
            check_result($sformatf("vec%0d", i), v, lat);
            release_result($sformatf("vec%0d", i));
        end

        // Hold in DONE with input noise
        v = vecs[0];
        run_txn(v.a, v.b, lat);
        check_result("hold", v, lat);
        for (int c = 0; c < 10; c++) begin
            A = $urandom; B = $urandom; in_valid = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold mantSmall", mantSmall, v.ms);
            chk("hold opA", opA, v.a);
        end
        in_valid = 1'b1;
        release_result("hold");
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("hold no stray accept", {31'd0, out_valid}, 32'd0);

        // Reset on the 5th shift edge of a d=24 transaction
        @(negedge clock);
        A = 32'h4B800000; B = 32'h3F800001; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("mid-shift busy", {30'd0, in_ready, out_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst mantSmall", mantSmall, 32'd0);
        chk("rst mantLarge", mantLarge, 32'd0);
        chk("rst exponentOut", {24'd0, exponentOut}, 32'd0);
        chk("rst opA", opA, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst release in_ready", {31'd0, in_ready}, 32'd1);
        v = '{32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 32'h80000000, 32'h80000000, 1, 6'b000000, 2'b00};
        run_txn(v.a, v.b, lat);
        check_result("after-rst", v, lat);
        release_result("after-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_operand_align.md
FP_OPERAND_ALIGN -- requirements
Module: fp_operand_align

Interface
REQ-001 The block SHALL have one parameter: MAX_SHIFT, default 26, the largest exponent difference handled by the shift loop.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 The block SHALL have ports A and B, input, 32 each, IEEE-754 single-precision operands.
REQ-007 The block SHALL have port out_valid, output, 1, aligned result held.
REQ-008 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-009 The block SHALL have ports opA and opB, output, 32 each, the registered copies of A and B.
REQ-010 The block SHALL have ports ANaN, BNaN, Ainf, Binf, Azero and Bzero, output, 1 each, per-operand class flags.
REQ-011 The block SHALL have ports signA and signB, output, 1 each, operand signs.
REQ-012 The block SHALL have port swapped, output, 1, set when B is the larger-magnitude operand.
REQ-013 The block SHALL have port exponentOut, output, 8, effective exponent of the larger operand.
REQ-014 The block SHALL have ports mantLarge and mantSmall, output, 32 each, significand in [31:8] with guard/round/sticky space in [7:0].

Function
REQ-015 Unpack SHALL work as follows: exp==0 gives hidden bit 0 and effective exponent 1; otherwise hidden bit 1 and effective exponent exp. The significand is {hidden, frac, 8'b0}.
REQ-016 Classification SHALL work as follows:
- NaN is exp==FF with frac!=0.
- inf is exp==FF with frac==0.
- zero is exp==0 with frac==0.
REQ-017 Ordering SHALL work as follows: the larger operand is the one with the larger {effective exponent, frac}; on a tie A is the larger (swapped=0).
REQ-018 The state machine SHALL have states IDLE, SHIFT and DONE, and in_ready SHALL be 1 only in IDLE with reset low.
REQ-019 In IDLE, an in_valid&&in_ready cycle SHALL register A, B, flags, signs, swapped, exponentOut, mantLarge and the unshifted small significand, and SHALL load count = exponent difference.
REQ-020 Acceptance SHALL transition as follows:
- special case (any NaN/inf/zero flag) goes to DONE with no shifting;
- difference 0 goes to DONE;
- difference > MAX_SHIFT sets mantSmall = 32'h1 if the small significand is nonzero, else 0, and goes to DONE;
- otherwise goes to SHIFT.
REQ-021 In SHIFT, each cycle SHALL:
- shift mantSmall right 1, with new bit0 = old bit0 | old bit1 (sticky);
- decrement count;
- go to DONE when count reaches 1 on the shift being performed.
REQ-022 Latency from accept at edge T SHALL be: out_valid high after edge T+1+d, with d = shift count (0 for special or collapsed cases).
REQ-023 In DONE, out_valid SHALL be 1 and all outputs SHALL hold stable while out_ready=0.
REQ-024 out_valid&&out_ready SHALL return the block to IDLE; no new operand is accepted in that same cycle (one transaction in flight).
REQ-025 in_valid SHALL be ignored outside IDLE, and A/B changes outside IDLE SHALL NOT affect held outputs.
REQ-026 Difference arithmetic SHALL be 8-bit unsigned (larger minus smaller effective exponent), never negative by construction.

Reset
REQ-027 Reset high at a clock edge SHALL force IDLE, out_valid=0, count=0, and all data/flag registers to 0, from any state including mid-SHIFT and DONE.
REQ-028 in_ready SHALL be 0 while reset is high and 1 on the first cycle after reset deasserts.
REQ-029 A transaction interrupted by reset SHALL be discarded, with no out_valid pulse.

Verification
REQ-030 Scenario: A=3F800000, B=40000000 accepted at T -> out_valid after T+2; swapped=1, exponentOut=80, mantLarge=80000000, mantSmall=40000000.
REQ-031 Scenario: A=4B800000, B=3F800001 -> d=24, out_valid after T+25; exponentOut=97, mantLarge=80000000, mantSmall=00000081 (sticky set).
REQ-032 Scenario: A=7F000000, B=3F800000 (diff 127) -> out_valid after T+1; mantSmall=00000001, mantLarge=80000000, exponentOut=FE.
REQ-033 Scenario: A=7FC00000, B=3F800000 -> out_valid after T+1; ANaN=1, opA=7FC00000, no shift cycles; separately, A=00000000 gives Azero=1.
REQ-034 Scenario: hold out_ready=0 for 10 cycles in DONE while toggling A/B/in_valid -> outputs unchanged and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 Scenario: reset asserted in the 5th SHIFT cycle of a d=24 case -> next cycle out_valid=0 and outputs 0; in_ready=1 after deassert; a following 1.0+1.0 transaction completes correctly (mantSmall=80000000).
